// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: one-hot result
// codes and FSM state constants.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
module chunk_compare #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock, with early
// exit on the first differing chunk and optional two's-complement ordering.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result
);
  import cmp_pkg::*;

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_magnitude_comparator: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
  end

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sm_q, sm_d;
  logic [2:0]       result_q, result_d;

  logic [CHUNK-1:0] x_sel, y_sel;
  logic             chunk_gt, chunk_lt;

  // Slice mux; in signed mode the top chunk's MSB is flipped so that an
  // unsigned compare of offset-binary values gives two's-complement order.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        x_sel = a_q[i*CHUNK +: CHUNK];
        y_sel = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sm_q && idx_q == IDX_TOP) begin
      x_sel[CHUNK-1] = ~x_sel[CHUNK-1];
      y_sel[CHUNK-1] = ~y_sel[CHUNK-1];
    end
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .x  (x_sel),
    .y  (y_sel),
    .gt (chunk_gt),
    .lt (chunk_lt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sm_d     = sm_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = IDX_TOP;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (chunk_gt) begin
          result_d = CMP_GT;
          state_d  = ST_DONE;
        end else if (chunk_lt) begin
          result_d = CMP_LT;
          state_d  = ST_DONE;
        end else if (idx_q == '0) begin
          result_d = CMP_EQ;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_TOP;
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sm_q     <= sm_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
